// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM states and line geometry.
package boot_pkg;

    // Number of image words packed into one backing-memory line.
    localparam int WORDS_PER_LINE = 4;

    // Line width for the default 32-bit word size.
    localparam int DEFAULT_XLEN = 32;
    localparam int LINE_BITS    = WORDS_PER_LINE * DEFAULT_XLEN;

    // Line width for an arbitrary word size.
    function automatic int line_bits(input int xlen);
        return WORDS_PER_LINE * xlen;
    endfunction

    // Loader states: FILL collects words, WRITE waits for the memory ack,
    // DONE and ERR are terminal until reset.
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } bl_state_t;

endpackage

// File: rtl/bl_line_packer.sv
// Line buffer: drops each accepted word into its lane, cleared after a line write.
module bl_line_packer
    import boot_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic                           clear,
    input  logic [1:0]                     idx,
    input  logic [XLEN-1:0]                word,
    output logic [WORDS_PER_LINE*XLEN-1:0] line
);

    generate
        for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_lane
            logic [XLEN-1:0] lane_reg;

            // Lane gi captures the word when it is the current fill slot; a
            // completed write (or reset) zeroes it so short last lines pad with 0.
            always_ff @(posedge clk) begin
                if (!rst || clear) begin
                    lane_reg <= '0;
                end else if (load && (idx == 2'(gi))) begin
                    lane_reg <= word;
                end
            end

            assign line[gi*XLEN +: XLEN] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/boot_loader.sv
// Boot loader: packs a word stream into 4-word lines, writes them to memory
// starting at BASE_LINE and releases the cpu reset once the image is loaded.
module boot_loader
    import boot_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int LINE_ADDR_BITS = 16,
    parameter int BASE_LINE      = 0,
    parameter int MAX_LINES      = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           In_valid,
    input  logic [XLEN-1:0]                In_data,
    input  logic                           In_last,
    output logic                           In_ready,
    output logic                           Bl_wb_we,
    output logic [LINE_ADDR_BITS-1:0]      Bl_wb_addr,
    output logic [WORDS_PER_LINE*XLEN-1:0] Bl_wb_wline,
    input  logic                           Bl_wb_ack,
    output logic                           Cpu_rst,
    output logic                           Bl_done,
    output logic                           Bl_err,
    output logic [LINE_ADDR_BITS+1:0]      Bl_word_cnt
);

    // Line counter needs one extra bit so it can hold MAX_LINES == 2^LINE_ADDR_BITS.
    localparam logic [LINE_ADDR_BITS:0]   MAX_L  = (LINE_ADDR_BITS+1)'(MAX_LINES);
    localparam logic [LINE_ADDR_BITS-1:0] BASE_L = LINE_ADDR_BITS'(BASE_LINE);

    bl_state_t                   state_reg, state_next;
    logic [1:0]                  word_idx_reg;
    logic [LINE_ADDR_BITS:0]     lines_written_reg;
    logic [LINE_ADDR_BITS+1:0]   word_cnt_reg;
    logic                        last_seen_reg;
    logic                        accept;
    logic                        write_done;

    assign accept     = In_valid && In_ready;
    assign write_done = (state_reg == WRITE) && Bl_wb_ack;

    bl_line_packer #(.XLEN(XLEN)) u_packer (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .clear (write_done),
        .idx   (word_idx_reg),
        .word  (In_data),
        .line  (Bl_wb_wline)
    );

    // Address wraps modulo 2^LINE_ADDR_BITS; the carry is discarded.
    assign Bl_wb_addr  = BASE_L + lines_written_reg[LINE_ADDR_BITS-1:0];
    assign Bl_word_cnt = word_cnt_reg;

    // State register and counters; reset discards any partial line or pending write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg         <= FILL;
            word_idx_reg      <= 2'd0;
            lines_written_reg <= '0;
            word_cnt_reg      <= '0;
            last_seen_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                word_idx_reg <= word_idx_reg + 2'd1;
                word_cnt_reg <= word_cnt_reg + (LINE_ADDR_BITS+2)'(1);
                if (In_last) begin
                    last_seen_reg <= 1'b1;
                end
            end
            if (write_done) begin
                word_idx_reg      <= 2'd0;
                lines_written_reg <= lines_written_reg + (LINE_ADDR_BITS+1)'(1);
            end
        end
    end

    // Next-state and Moore outputs; overflow is detected before any write is issued.
    always_comb begin
        state_next = state_reg;
        In_ready   = 1'b0;
        Bl_wb_we   = 1'b0;
        Cpu_rst    = 1'b1;
        Bl_done    = 1'b0;
        Bl_err     = 1'b0;
        case (state_reg)
            FILL: begin
                In_ready = 1'b1;
                if (In_valid && ((word_idx_reg == 2'd3) || In_last)) begin
                    state_next = (lines_written_reg == MAX_L) ? ERR : WRITE;
                end
            end
            WRITE: begin
                Bl_wb_we = 1'b1;
                if (Bl_wb_ack) begin
                    state_next = last_seen_reg ? DONE : FILL;
                end
            end
            DONE: begin
                Cpu_rst = 1'b0;
                Bl_done = 1'b1;
            end
            ERR: begin
                Bl_err = 1'b1;
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: two instances (default geometry, and BASE_LINE=0xFFFF
// with MAX_LINES=2) driven by table vectors, directed reset cases and random images.
module tb_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         rst_n, in_valid, in_last, in_ready, wb_we, wb_ack, cpu_rst, done, err;
    logic [1:0][31:0]   in_data;
    logic [1:0][15:0]   wb_addr;
    logic [1:0][127:0]  wb_wline;
    logic [1:0][17:0]   word_cnt;

    boot_loader #(.XLEN(32), .LINE_ADDR_BITS(16), .BASE_LINE(0), .MAX_LINES(1024)) dut_a (
        .clk(clk), .rst(rst_n[0]), .In_valid(in_valid[0]), .In_data(in_data[0]),
        .In_last(in_last[0]), .In_ready(in_ready[0]), .Bl_wb_we(wb_we[0]),
        .Bl_wb_addr(wb_addr[0]), .Bl_wb_wline(wb_wline[0]), .Bl_wb_ack(wb_ack[0]),
        .Cpu_rst(cpu_rst[0]), .Bl_done(done[0]), .Bl_err(err[0]), .Bl_word_cnt(word_cnt[0])
    );

    boot_loader #(.XLEN(32), .LINE_ADDR_BITS(16), .BASE_LINE(16'hFFFF), .MAX_LINES(2)) dut_b (
        .clk(clk), .rst(rst_n[1]), .In_valid(in_valid[1]), .In_data(in_data[1]),
        .In_last(in_last[1]), .In_ready(in_ready[1]), .Bl_wb_we(wb_we[1]),
        .Bl_wb_addr(wb_addr[1]), .Bl_wb_wline(wb_wline[1]), .Bl_wb_ack(wb_ack[1]),
        .Cpu_rst(cpu_rst[1]), .Bl_done(done[1]), .Bl_err(err[1]), .Bl_word_cnt(word_cnt[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0]  img[$];
    logic [15:0]  exp_addr[$], obs_addr[$];
    logic [127:0] exp_line[$], obs_line[$];
    bit           exp_done, exp_err;
    int           exp_cnt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] base_of(input int d);
        return (d == 1) ? 16'hFFFF : 16'h0000;
    endfunction

    function automatic int max_of(input int d);
        return (d == 1) ? 2 : 1024;
    endfunction

    // Reference: chop the image into 4-word lines (short tail padded with zero),
    // write at most max lines; an image needing more lines ends in error after
    // the overflowing line has been filled.
    task automatic model(input int d);
        int n, nlines, lim, mx;
        logic [127:0] ln;
        n      = img.size();
        mx     = max_of(d);
        nlines = (n + 3) / 4;
        lim    = (nlines > mx) ? mx : nlines;
        exp_addr.delete();
        exp_line.delete();
        for (int l = 0; l < lim; l++) begin
            ln = '0;
            for (int k = 0; k < 4; k++)
                if (4*l + k < n) ln[k*32 +: 32] = img[4*l + k];
            exp_line.push_back(ln);
            exp_addr.push_back(16'(base_of(d) + 16'(l)));
        end
        exp_err  = (nlines > mx);
        exp_done = !exp_err;
        exp_cnt  = exp_err ? ((n < 4*(mx+1)) ? n : 4*(mx+1)) : n;
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        rst_n[d] = 1'b0; in_valid[d] = 1'b0; in_last[d] = 1'b0; wb_ack[d] = 1'b0;
        @(negedge clk);
        check($sformatf("rst%0d_ready", d), 128'(in_ready[d]), 128'd1);
        check($sformatf("rst%0d_we", d),    128'(wb_we[d]),    128'd0);
        check($sformatf("rst%0d_cpurst", d),128'(cpu_rst[d]),  128'd1);
        check($sformatf("rst%0d_flags", d), 128'({done[d], err[d]}), 128'd0);
        check($sformatf("rst%0d_cnt", d),   128'(word_cnt[d]), 128'd0);
        rst_n[d] = 1'b1;
    endtask

    // Streams img into dut d, acking writes ack_delay cycles after we rises,
    // then compares every write and the final status against the model.
    task automatic run_image(input int d, input int ack_delay, input bit gaps, input string tag);
        int idx, wait_cnt, n;
        bit ready_s, we_s, valid_s, stable_ok, cpu_ok, finished;
        logic [15:0]  a0;
        logic [127:0] l0;
        idx = 0; wait_cnt = 0; stable_ok = 1; cpu_ok = 1; finished = 0;
        a0 = '0; l0 = '0;
        n = img.size();
        obs_addr.delete();
        obs_line.delete();
        model(d);
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (done[d] || err[d]) begin
                finished = 1;
            end else begin
                if (!cpu_rst[d]) cpu_ok = 0;
                we_s    = wb_we[d];
                ready_s = in_ready[d];
                if (we_s) begin
                    if (wait_cnt == 0) begin
                        a0 = wb_addr[d];
                        l0 = wb_wline[d];
                    end else if (wb_addr[d] !== a0 || wb_wline[d] !== l0) begin
                        stable_ok = 0;
                    end
                    if (ready_s) stable_ok = 0;
                    wait_cnt++;
                    wb_ack[d] = (wait_cnt > ack_delay);
                end else begin
                    wait_cnt  = 0;
                    wb_ack[d] = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                if (idx < n && (!gaps || $urandom_range(0, 1) == 1)) begin
                    in_valid[d] = 1'b1;
                    in_data[d]  = img[idx];
                    in_last[d]  = (idx == n - 1);
                end else begin
                    in_valid[d] = 1'b0;
                    in_data[d]  = $urandom;
                    in_last[d]  = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                valid_s = in_valid[d];
                @(posedge clk);
                if (valid_s && ready_s) idx++;
                if (we_s && wb_ack[d]) begin
                    obs_addr.push_back(a0);
                    obs_line.push_back(l0);
                    wait_cnt = 0;
                end
                @(negedge clk);
            end
        end
        in_valid[d] = 1'b0; in_last[d] = 1'b0; wb_ack[d] = 1'b0;
        check({tag, "_finished"}, 128'(finished), 128'd1);
        check({tag, "_nwrites"}, 128'(obs_addr.size()), 128'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 128'(obs_addr[i]), 128'(exp_addr[i]));
            check($sformatf("%s_line%0d", tag, i), obs_line[i], exp_line[i]);
        end
        check({tag, "_done"},   128'(done[d]),     128'(exp_done));
        check({tag, "_err"},    128'(err[d]),      128'(exp_err));
        check({tag, "_cpurst"}, 128'(cpu_rst[d]),  128'(!exp_done));
        check({tag, "_cnt"},    128'(word_cnt[d]), 128'(exp_cnt));
        check({tag, "_stable"}, 128'(stable_ok),   128'd1);
        check({tag, "_cpu_held"}, 128'(cpu_ok),    128'd1);
        // Terminal states must ignore further words and acks.
        in_valid[d] = 1'b1; in_data[d] = $urandom; wb_ack[d] = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_term_ready"}, 128'({in_ready[d], wb_we[d]}), 128'd0);
        check({tag, "_term_cnt"},   128'(word_cnt[d]), 128'(exp_cnt));
        check({tag, "_term_state"}, 128'({done[d], err[d]}), 128'({exp_done, exp_err}));
        in_valid[d] = 1'b0; wb_ack[d] = 1'b0;
        $display("image %s: dut%0d words=%0d writes=%0d done=%0d err=%0d cnt=%0d",
                 tag, d, n, obs_addr.size(), done[d], err[d], word_cnt[d]);
    endtask

    typedef struct {
        int d; int n; int ack_delay; bit gaps;
        int exp_writes; bit exp_done; bit exp_err; int exp_cnt;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = '0; in_valid = '0; in_last = '0; wb_ack = '0; in_data = '0;

        tbl[0] = '{0,  8, 1, 0, 2, 1, 0,  8};  // two full lines, ack one cycle late
        tbl[1] = '{0,  5, 1, 0, 2, 1, 0,  5};  // short last line
        tbl[2] = '{0,  8, 3, 0, 2, 1, 0,  8};  // slow ack with valid held
        tbl[3] = '{1, 12, 1, 0, 2, 0, 1, 12};  // overflow at third line
        tbl[4] = '{1,  8, 0, 0, 2, 1, 0,  8};  // address wrap from 0xFFFF
        tbl[5] = '{0,  1, 0, 1, 1, 1, 0,  1};  // single word image
        tbl[6] = '{0,  4, 2, 1, 1, 1, 0,  4};  // exactly one line
        tbl[7] = '{1,  9, 1, 1, 2, 0, 1,  9};  // overflow on a short line

        do_reset(0);
        do_reset(1);

        for (int t = 0; t < 8; t++) begin
            img.delete();
            for (int i = 0; i < tbl[t].n; i++) img.push_back(32'((i + 1) * 17));
            do_reset(tbl[t].d);
            run_image(tbl[t].d, tbl[t].ack_delay, tbl[t].gaps, $sformatf("vec%0d", t));
            check($sformatf("vec%0d_tbl_writes", t), 128'(obs_addr.size()), 128'(tbl[t].exp_writes));
            check($sformatf("vec%0d_tbl_status", t), 128'({done[tbl[t].d], err[tbl[t].d]}),
                  128'({tbl[t].exp_done, tbl[t].exp_err}));
            check($sformatf("vec%0d_tbl_cnt", t), 128'(word_cnt[tbl[t].d]), 128'(tbl[t].exp_cnt));
            if (t == 0 && obs_line.size() == 2) begin
                check("vec0_line1", obs_line[1], {32'h88, 32'h77, 32'h66, 32'h55});
                check("vec0_line0", obs_line[0], {32'h44, 32'h33, 32'h22, 32'h11});
                check("vec0_addr1", 128'(obs_addr[1]), 128'd1);
            end
            if (t == 1 && obs_line.size() == 2)
                check("vec1_short", obs_line[1], {96'h0, 32'h55});
            if (t == 4 && obs_addr.size() == 2)
                check("vec4_wrap", 128'({obs_addr[0], obs_addr[1]}), 128'({16'hFFFF, 16'h0000}));
        end

        // Reset after two accepted words: partial line dropped.
        do_reset(0);
        in_valid[0] = 1'b1; in_last[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_data[0] = 32'hA0 + 32'(i);
            @(negedge clk);
        end
        check("mid_cnt2", 128'(word_cnt[0]), 128'd2);
        check("mid_nowrite", 128'(wb_we[0]), 128'd0);
        rst_n[0] = 1'b0; in_valid[0] = 1'b0;
        @(negedge clk);
        check("mid_rst_cnt", 128'(word_cnt[0]), 128'd0);
        check("mid_rst_we", 128'(wb_we[0]), 128'd0);
        rst_n[0] = 1'b1;
        // Reset while a write is pending: write abandoned.
        in_valid[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data[0] = 32'hB0 + 32'(i);
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        check("pend_we", 128'(wb_we[0]), 128'd1);
        rst_n[0] = 1'b0;
        @(negedge clk);
        check("pend_rst_we", 128'(wb_we[0]), 128'd0);
        rst_n[0] = 1'b1;
        img.delete();
        for (int i = 0; i < 4; i++) img.push_back(32'hC0 + 32'(i));
        run_image(0, 1, 0, "reload");
        if (obs_addr.size() == 1) check("reload_base", 128'(obs_addr[0]), 128'd0);

        // Random images on either instance.
        for (int r = 0; r < 24; r++) begin
            int d, n;
            d = $urandom_range(0, 1);
            n = $urandom_range(1, 14);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom);
            do_reset(d);
            run_image(d, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
